i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- Responder-side I2C target for the FPGA; complements the existing I2C master so the two can be looped back on-chip or across pins.
- Oversamples SCL/SDA on the system clock, detects START/STOP, and matches a fixed 7-bit address.
- Accepts write bytes into Data_OUT and serves read bytes from Data_IN.
- Drives SDA open-drain through an output-enable only; it never drives SDA high.

Parameters:
SLAVE_ADDR, 7'h19, 7-bit target address (master sends 8'b00110011 for a read to this address).

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  asynchronous, active-high reset.
SCL  input  1  I2C clock from pin; asynchronous to CLK.
SDA_IN  input  1  I2C data as seen on pin; asynchronous to CLK.
SDA_OE  output  1  1 = pull SDA low, 0 = release (pad ties output value to 0).
Data_IN  input  8  byte returned to the master on a read; sampled when a read byte is loaded.
Data_OUT  output  8  last byte written by the master.
Data_Valid  output  1  one-CLK pulse when Data_OUT updates.
Rd_Req  output  1  one-CLK pulse requesting the next Data_IN byte.
Busy  output  1  high while this slave is addressed.

Behaviour:
- Reset: async, active-high. Clears state to IDLE, SDA_OE=0, Data_OUT=0, Data_Valid=0, Rd_Req=0, Busy=0, bit counter=0, shift reg=0.
- Synchronisation and edges:
  - SCL and SDA_IN each pass through a 2-FF synchroniser, plus one history FF for edge detect.
  - Edge events fire 3 CLK after the pin transition.
- Bus events:
  - START = SDA falls while SCL high. STOP = SDA rises while SCL high.
  - SCL high time and low time are each at least 4 CLK; SDA is stable around SCL rise.
- Data timing:
  - Received bits are sampled on the SCL rising event.
  - SDA_OE changes only on the SCL falling event, registered, so it is valid 1 CLK after that event.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK.
- START (including repeated START) from any state → ADDR, bit counter=0, SDA_OE=0, Busy=0.
- STOP from any state → IDLE, SDA_OE=0, Busy=0.
- ADDR:
  - Shift 8 bits MSB first.
  - After the 8th rising event: if bits[7:1]==SLAVE_ADDR, set Busy=1 and, if R/W=1, pulse Rd_Req.
  - On the next falling event, set SDA_OE=1 → ADDR_ACK.
  - On mismatch → IDLE with SDA_OE=0 (ignore bus until the next START).
- ADDR_ACK, on the falling event ending the ACK clock:
  - R/W=0: SDA_OE=0 → WRITE.
  - R/W=1: load shift reg from Data_IN, SDA_OE=~Data_IN[7] → READ.
- WRITE:
  - Shift 8 bits.
  - After the 8th rising event: Data_OUT ← byte, Data_Valid pulse for 1 CLK.
  - Next falling event: SDA_OE=1 → WRITE_ACK.
- WRITE_ACK: on the next falling event, SDA_OE=0 → WRITE; bit counter=0.
- READ:
  - On each falling event after bit 0 was driven, shift and drive SDA_OE=~next bit.
  - After the falling event ending bit 0 (8th bit), SDA_OE=0 → READ_ACK.
- READ_ACK, sample SDA on the rising event:
  - 0 (ACK): pulse Rd_Req; on the next falling event, load Data_IN and drive its MSB → READ.
  - 1 (NACK): Busy=0 → IDLE (release; await STOP/START).
- Timing requirement on Data_IN: it must be stable from the Rd_Req pulse until the following SCL falling event, at least 4 CLK later.
- Simultaneous events:
  - START/STOP take priority over bit sampling in the same CLK.
  - SCL rising and falling events cannot coincide.
- Reset mid-transfer releases SDA immediately (asynchronous).

Test Plan:
- Reset: assert RST during a byte → SDA_OE=0, Data_OUT=0, Busy=0 within the same cycle; no ACK on subsequent clocks until a new START.
- Write: START, 8'h32, 8'hF0, STOP with SCL period 20 CLK → SDA_OE=1 during both ACK clocks; Data_OUT=8'hF0 with a single Data_Valid pulse; Busy 1→0 at STOP.
- Address mismatch: START, 8'h34 (addr 0x1A), then 8'hF0 → SDA_OE never asserted; Data_Valid never pulses.
- Read with ACK then NACK:
  - Stimulus: START, 8'h33 with Data_IN=8'hA5, master ACKs; then Data_IN=8'h3C, master NACKs.
  - Response: SDA_OE pattern gives bits 10100101 then 00111100; two Rd_Req pulses; after NACK, SDA_OE=0 and Busy=0.
- Repeated START: write 8'h32, 8'h11, then START, 8'h33 → Data_OUT=8'h11; second address ACKed; read proceeds normally.
- STOP mid-byte: STOP after 4 data bits of a write → IDLE, Data_OUT unchanged, no Data_Valid pulse, SDA_OE=0.

Source files
------------

// File: rtl/i2c_slave_if.sv
// Bus bundle for the I2C target: pin-side SCL/SDA plus the byte-level user side.
`timescale 1ns/1ps
interface i2c_slave_if;
  logic       SCL;
  logic       SDA_IN;
  logic       SDA_OE;
  logic [7:0] Data_IN;
  logic [7:0] Data_OUT;
  logic       Data_Valid;
  logic       Rd_Req;
  logic       Busy;

  modport slave (
    input  SCL, SDA_IN, Data_IN,
    output SDA_OE, Data_OUT, Data_Valid, Rd_Req, Busy
  );

  modport master (
    output SCL, SDA_IN, Data_IN,
    input  SDA_OE, Data_OUT, Data_Valid, Rd_Req, Busy
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C target with a fixed 7-bit address. SCL/SDA are oversampled on CLK,
// START/STOP are detected from the synchronised pins, and SDA is only ever
// pulled low through SDA_OE.
//
// state     | meaning
// IDLE      | not addressed, ignoring the bus until START
// ADDR      | shifting in address + R/W
// ADDR_ACK  | pulling SDA low for the address ACK
// WRITE     | shifting in a data byte from the master
// WRITE_ACK | pulling SDA low for the data ACK
// READ      | driving a data byte out, MSB first
// READ_ACK  | released, sampling the master's ACK/NACK
`timescale 1ns/1ps
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h19
) (
  input  logic    CLK,
  input  logic    RST,
  i2c_slave_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK
  } state_t;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       rw;

  logic       scl_rise, scl_fall, scl_high;
  logic       start_ev, stop_ev;
  logic [7:0] rx_byte;

  // Two-stage synchronisers plus one history stage; reset to the idle-bus level
  // so leaving reset never looks like a bus edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= bus.SCL;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= bus.SDA_IN;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  // SCL must be high in both the current and previous sample so an SDA change
  // that lands in the same sample as an SCL edge is not taken as START/STOP.
  assign scl_high = scl_s2 & scl_d;
  assign start_ev = scl_high & sda_d & ~sda_s2;
  assign stop_ev  = scl_high & ~sda_d & sda_s2;
  assign rx_byte  = {shift_reg[6:0], sda_s2};

  // Protocol FSM; every output is registered here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      bit_cnt        <= 4'd0;
      shift_reg      <= 8'd0;
      rw             <= 1'b0;
      bus.SDA_OE     <= 1'b0;
      bus.Data_OUT   <= 8'd0;
      bus.Data_Valid <= 1'b0;
      bus.Rd_Req     <= 1'b0;
      bus.Busy       <= 1'b0;
    end else begin
      bus.Data_Valid <= 1'b0;
      bus.Rd_Req     <= 1'b0;
      if (start_ev) begin
        state      <= ADDR;
        bit_cnt    <= 4'd0;
        bus.SDA_OE <= 1'b0;
        bus.Busy   <= 1'b0;
      end else if (stop_ev) begin
        state      <= IDLE;
        bus.SDA_OE <= 1'b0;
        bus.Busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end
          ADDR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shift_reg <= rx_byte;
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  bus.Busy   <= 1'b1;
                  rw         <= rx_byte[0];
                  bus.Rd_Req <= rx_byte[0];
                end else begin
                  state <= IDLE;
                end
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bus.SDA_OE <= 1'b1;
              state      <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (rw) begin
                shift_reg  <= bus.Data_IN;
                bus.SDA_OE <= ~bus.Data_IN[7];
                state      <= READ;
              end else begin
                bus.SDA_OE <= 1'b0;
                state      <= WRITE;
              end
            end
          end
          WRITE: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shift_reg <= rx_byte;
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bus.Data_OUT   <= rx_byte;
                bus.Data_Valid <= 1'b1;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bus.SDA_OE <= 1'b1;
              state      <= WRITE_ACK;
            end
          end
          WRITE_ACK: begin
            if (scl_fall) begin
              bus.SDA_OE <= 1'b0;
              bit_cnt    <= 4'd0;
              state      <= WRITE;
            end
          end
          READ: begin
            // bit_cnt counts falling edges that end a driven bit; the 8th ends bit 0.
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                bus.SDA_OE <= 1'b0;
                bit_cnt    <= 4'd0;
                state      <= READ_ACK;
              end else begin
                shift_reg  <= {shift_reg[6:0], 1'b0};
                bus.SDA_OE <= ~shift_reg[6];
                bit_cnt    <= bit_cnt + 4'd1;
              end
            end
          end
          READ_ACK: begin
            // A falling edge here always follows an ACK'd rising edge; NACK leaves the state.
            if (scl_rise) begin
              if (!sda_s2) begin
                bus.Rd_Req <= 1'b1;
              end else begin
                bus.Busy <= 1'b0;
                state    <= IDLE;
              end
            end else if (scl_fall) begin
              shift_reg  <= bus.Data_IN;
              bus.SDA_OE <= ~bus.Data_IN[7];
              bit_cnt    <= 4'd0;
              state      <= READ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, wired-AND SDA, directed
// scenarios followed by random transactions against a transaction-level model.
`timescale 1ns/1ps
module tb_i2c_slave;
  logic CLK = 1'b0;
  logic RST;
  logic m_sda;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int rd_cnt = 0;
  int oe_cnt = 0;

  i2c_slave_if bus();
  assign bus.SDA_IN = m_sda & ~bus.SDA_OE;

  i2c_slave #(.SLAVE_ADDR(7'h19)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bus.Data_Valid) dv_cnt <= dv_cnt + 1;
    if (bus.Rd_Req)     rd_cnt <= rd_cnt + 1;
    if (bus.SDA_OE)     oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One SCL period of 20 CLK; returns the bus SDA sampled mid-high.
  task automatic send_bit(input logic b, output logic s);
    wait_clk(2);
    m_sda = b;
    wait_clk(8);
    bus.SCL = 1'b1;
    wait_clk(5);
    s = bus.SDA_IN;
    wait_clk(5);
    bus.SCL = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clk(2);
    m_sda = 1'b1;
    wait_clk(8);
    bus.SCL = 1'b1;
    wait_clk(6);
    m_sda = 1'b0;
    wait_clk(6);
    bus.SCL = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(2);
    m_sda = 1'b0;
    wait_clk(8);
    bus.SCL = 1'b1;
    wait_clk(6);
    m_sda = 1'b1;
    wait_clk(10);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
  endtask

  // After the slave has loaded Data_IN, garble it so a late load shows up.
  task automatic scramble_din();
    wait_clk(6);
    bus.Data_IN = 8'($urandom);
  endtask

  initial begin
    logic       a;
    logic [7:0] rd;
    logic [7:0] exp_dout;
    logic [7:0] din;
    logic [7:0] d;
    logic [6:0] addr7;
    logic       matched, rw_bit, last;
    int         n, dv0, rd0, oe0, exp_dv, exp_rd;

    RST = 1'b1;
    bus.SCL = 1'b1;
    m_sda = 1'b1;
    bus.Data_IN = 8'h00;
    exp_dout = 8'h00;
    wait_clk(3);
    check("rst_sda_oe", 32'(bus.SDA_OE), 32'd0);
    check("rst_dout", 32'(bus.Data_OUT), 32'd0);
    check("rst_dv", 32'(bus.Data_Valid), 32'd0);
    check("rst_rdreq", 32'(bus.Rd_Req), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    RST = 1'b0;
    wait_clk(5);

    // Write 0xF0 to our address
    dv0 = dv_cnt;
    i2c_start();
    write_byte(8'h32, a);
    check("wr_addr_ack", 32'(a), 32'd0);
    write_byte(8'hF0, a);
    check("wr_data_ack", 32'(a), 32'd0);
    check("wr_busy", 32'(bus.Busy), 32'd1);
    check("wr_dout", 32'(bus.Data_OUT), 32'hF0);
    check("wr_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
    i2c_stop();
    check("wr_busy_stop", 32'(bus.Busy), 32'd0);
    exp_dout = 8'hF0;

    // Address mismatch
    dv0 = dv_cnt;
    oe0 = oe_cnt;
    i2c_start();
    write_byte(8'h34, a);
    check("mm_addr_nack", 32'(a), 32'd1);
    write_byte(8'hF0, a);
    check("mm_data_nack", 32'(a), 32'd1);
    i2c_stop();
    check("mm_oe_never", 32'(oe_cnt - oe0), 32'd0);
    check("mm_dv_never", 32'(dv_cnt - dv0), 32'd0);
    check("mm_dout", 32'(bus.Data_OUT), 32'(exp_dout));

    // Read A5 (ACK) then 3C (NACK)
    rd0 = rd_cnt;
    bus.Data_IN = 8'hA5;
    i2c_start();
    write_byte(8'h33, a);
    check("rd_addr_ack", 32'(a), 32'd0);
    check("rd_busy", 32'(bus.Busy), 32'd1);
    scramble_din();
    read_byte(rd);
    check("rd_byte0", 32'(rd), 32'hA5);
    bus.Data_IN = 8'h3C;
    send_bit(1'b0, a);
    scramble_din();
    read_byte(rd);
    check("rd_byte1", 32'(rd), 32'h3C);
    send_bit(1'b1, a);
    check("rd_nack_oe", 32'(bus.SDA_OE), 32'd0);
    check("rd_nack_busy", 32'(bus.Busy), 32'd0);
    check("rd_rdreq_pulses", 32'(rd_cnt - rd0), 32'd2);
    i2c_stop();

    // Repeated START: write 0x11, then read
    i2c_start();
    write_byte(8'h32, a);
    check("rs_wr_addr_ack", 32'(a), 32'd0);
    write_byte(8'h11, a);
    check("rs_wr_data_ack", 32'(a), 32'd0);
    exp_dout = 8'h11;
    din = 8'($urandom);
    bus.Data_IN = din;
    i2c_start();
    write_byte(8'h33, a);
    check("rs_rd_addr_ack", 32'(a), 32'd0);
    check("rs_dout", 32'(bus.Data_OUT), 32'h11);
    scramble_din();
    read_byte(rd);
    check("rs_rd_byte", 32'(rd), 32'(din));
    send_bit(1'b1, a);
    i2c_stop();

    // STOP after 4 data bits
    i2c_start();
    write_byte(8'h32, a);
    check("sm_addr_ack", 32'(a), 32'd0);
    dv0 = dv_cnt;
    send_bit(1'b1, a);
    send_bit(1'b0, a);
    send_bit(1'b1, a);
    send_bit(1'b1, a);
    i2c_stop();
    check("sm_dout", 32'(bus.Data_OUT), 32'(exp_dout));
    check("sm_dv", 32'(dv_cnt - dv0), 32'd0);
    check("sm_oe", 32'(bus.SDA_OE), 32'd0);
    check("sm_busy", 32'(bus.Busy), 32'd0);

    // Reset during the address ACK clock
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      d = 8'h32;
      send_bit(d[i], a);
    end
    wait_clk(2);
    m_sda = 1'b1;
    wait_clk(8);
    bus.SCL = 1'b1;
    wait_clk(5);
    check("rs_pre_oe", 32'(bus.SDA_OE), 32'd1);
    RST = 1'b1;
    #1;
    check("rst_mid_oe", 32'(bus.SDA_OE), 32'd0);
    check("rst_mid_busy", 32'(bus.Busy), 32'd0);
    check("rst_mid_dout", 32'(bus.Data_OUT), 32'd0);
    exp_dout = 8'h00;
    wait_clk(2);
    RST = 1'b0;
    wait_clk(3);
    bus.SCL = 1'b0;
    oe0 = oe_cnt;
    write_byte(8'h32, a);
    check("rst_post_nack", 32'(a), 32'd1);
    check("rst_post_oe", 32'(oe_cnt - oe0), 32'd0);
    i2c_stop();

    // Random transactions against the transaction-level model
    for (int t = 0; t < 10; t++) begin
      matched = ($urandom_range(0, 3) != 0);
      addr7   = matched ? 7'h19 : 7'(7'h19 + 7'($urandom_range(1, 127)));
      rw_bit  = 1'($urandom_range(0, 1));
      n       = $urandom_range(1, 3);
      dv0     = dv_cnt;
      rd0     = rd_cnt;
      exp_dv  = 0;
      exp_rd  = 0;
      din     = 8'($urandom);
      bus.Data_IN = din;
      i2c_start();
      write_byte({addr7, rw_bit}, a);
      check("rnd_addr_ack", 32'(a), matched ? 32'd0 : 32'd1);
      check("rnd_busy", 32'(bus.Busy), 32'(matched));
      if (rw_bit) begin
        scramble_din();
        if (matched) exp_rd = n;
        for (int k = 0; k < n; k++) begin
          read_byte(rd);
          check("rnd_rd_byte", 32'(rd), matched ? 32'(din) : 32'hFF);
          last = (k == n - 1);
          if (!last) begin
            din = 8'($urandom);
            bus.Data_IN = din;
          end
          send_bit(last, a);
          if (!last) scramble_din();
        end
        check("rnd_rd_oe", 32'(bus.SDA_OE), 32'd0);
        check("rnd_rd_busy", 32'(bus.Busy), 32'd0);
      end else begin
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          write_byte(d, a);
          check("rnd_wr_ack", 32'(a), matched ? 32'd0 : 32'd1);
          if (matched) begin
            exp_dout = d;
            exp_dv++;
          end
        end
      end
      i2c_stop();
      check("rnd_busy_stop", 32'(bus.Busy), 32'd0);
      check("rnd_dout", 32'(bus.Data_OUT), 32'(exp_dout));
      check("rnd_dv", 32'(dv_cnt - dv0), 32'(exp_dv));
      check("rnd_rdreq", 32'(rd_cnt - rd0), 32'(exp_rd));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
